// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - request/response handshake bundle for the iterative mul/div unit
interface muldiv_iter_if #(
   parameter int XLEN = 64
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output flush, in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  flush, in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle multiply/divide unit with sign fix-up and W ops
module muldiv_iter #(
   parameter int XLEN = 64,
   parameter bit W_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_iter_if.slave bus
);
   // Word ops only exist on a 64-bit datapath.
   localparam bit W_OK = (XLEN == 64) && W_EN;
   localparam int CW   = $clog2(XLEN);

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t          r_state;
   logic [2:0]      r_fn;
   logic            r_word;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_hi;      // product high half / partial remainder
   logic [XLEN-1:0] r_lo;      // multiplier then product low half / dividend then quotient
   logic [XLEN-1:0] r_mc;      // |multiplicand| or |divisor|
   logic [CW-1:0]   r_cnt;
   logic            r_neg;
   logic [XLEN-1:0] r_result;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            r_busy;

   logic            w_in_word;
   logic [XLEN-1:0] w_in_a;
   logic [XLEN-1:0] w_in_b;
   logic [XLEN-1:0] w_in_min;
   logic [XLEN-1:0] w_in_ones;
   logic            w_in_div0;
   logic            w_in_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_spec_res;

   logic            w_un_a;
   logic            w_sa;
   logic            w_sb;
   logic [XLEN-1:0] w_a_n;
   logic [XLEN-1:0] w_b_n;
   logic [XLEN-1:0] w_a_abs;
   logic [XLEN-1:0] w_b_abs;
   logic            w_neg;
   logic [XLEN:0]   w_mul_sum;
   logic [XLEN-1:0] w_mul_lo;
   logic [XLEN:0]   w_div_rsh;
   logic [XLEN:0]   w_div_diff;
   logic            w_div_nb;
   logic [XLEN-1:0] w_calc_hi;
   logic [XLEN-1:0] w_calc_lo;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0] w_quo;
   logic [XLEN-1:0] w_rem;
   logic [XLEN-1:0] w_fix_raw;
   logic [XLEN-1:0] w_fix_res;

   // Keep only the low 32 bits (zero-extended) when operating on words.
   function automatic logic [XLEN-1:0] f_norm(input logic [XLEN-1:0] x, input logic word);
      return word ? XLEN'(x[31:0]) : x;
   endfunction

   // Sign-extend bit 31 across the datapath for word results.
   function automatic logic [XLEN-1:0] f_sext(input logic [XLEN-1:0] x, input logic word);
      return word ? XLEN'($signed(x[31:0])) : x;
   endfunction

   // Top bit of the effective N-bit operand.
   function automatic logic f_msb(input logic [XLEN-1:0] x, input logic word);
      return word ? x[31] : x[XLEN-1];
   endfunction

   // Request decode: word form and the divide shortcuts, judged on the raw operands.
   always_comb begin
      w_in_word = W_OK && bus.op[3] && (bus.op[2] || (bus.op[1:0] == 2'b00));
      w_in_a    = f_norm(bus.a, w_in_word);
      w_in_b    = f_norm(bus.b, w_in_word);
      w_in_min  = w_in_word ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
      w_in_ones = w_in_word ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
      w_in_div0 = bus.op[2] && (w_in_b == '0);
      w_in_ovf  = bus.op[2] && !bus.op[0] && (w_in_a == w_in_min) && (w_in_b == w_in_ones);
      w_special = w_in_div0 || w_in_ovf;
      if (w_in_div0) begin
         w_spec_res = bus.op[1] ? f_sext(bus.a, w_in_word) : {XLEN{1'b1}};
      end else begin
         w_spec_res = bus.op[1] ? '0 : f_sext(bus.a, w_in_word);
      end
   end

   // Datapath: operand magnitudes, one shift-add / restoring-subtract step, and the final fix-up.
   always_comb begin
      w_un_a  = r_fn[0] && (r_fn[1] || r_fn[2]);
      w_sa    = !w_un_a && f_msb(r_a, r_word);
      w_sb    = ((r_fn[2] && !r_fn[0]) || (r_fn[2:1] == 2'b00)) && f_msb(r_b, r_word);
      w_a_n   = f_norm(r_a, r_word);
      w_b_n   = f_norm(r_b, r_word);
      w_a_abs = w_sa ? f_norm(-w_a_n, r_word) : w_a_n;
      w_b_abs = w_sb ? f_norm(-w_b_n, r_word) : w_b_n;
      // mulhsu and rem take their sign from rs1 alone.
      w_neg   = ((r_fn == 3'b010) || (r_fn[2:1] == 2'b11)) ? w_sa : (w_sa ^ w_sb);

      // The bit leaving the high half lands at bit N-1 of the low half.
      w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
      w_mul_lo  = r_lo >> 1;
      if (r_word) begin
         w_mul_lo[31] = w_mul_sum[0];
      end else begin
         w_mul_lo[XLEN-1] = w_mul_sum[0];
      end

      // Borrow out of the (XLEN+1)-bit trial subtraction means the divisor did not fit.
      w_div_rsh  = {r_hi, f_msb(r_lo, r_word)};
      w_div_diff = w_div_rsh - {1'b0, r_mc};
      w_div_nb   = !w_div_diff[XLEN];

      if (r_fn[2]) begin
         w_calc_hi = w_div_nb ? w_div_diff[XLEN-1:0] : w_div_rsh[XLEN-1:0];
         w_calc_lo = {r_lo[XLEN-2:0], w_div_nb};
      end else begin
         w_calc_hi = w_mul_sum[XLEN:1];
         w_calc_lo = w_mul_lo;
      end

      w_prod     = r_word ? (({{XLEN{1'b0}}, r_hi} << 32) | {{XLEN{1'b0}}, r_lo}) : {r_hi, r_lo};
      w_prod_fix = r_neg ? -w_prod : w_prod;
      w_quo      = r_neg ? -r_lo : r_lo;
      w_rem      = r_neg ? -r_hi : r_hi;
      case (r_fn)
         3'b000:                 w_fix_raw = w_prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_raw = w_prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_raw = w_quo;
         default:                w_fix_raw = w_rem;
      endcase
      w_fix_res = f_sext(w_fix_raw, r_word);
   end

   // Control FSM; flush leaves the result register alone, reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_fn        <= '0;
         r_word      <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_mc        <= '0;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         r_result    <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (bus.flush) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_fn       <= bus.op[2:0];
                  r_word     <= w_in_word;
                  r_a        <= bus.a;
                  r_b        <= bus.b;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  if (w_special) begin
                     r_result    <= w_spec_res;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_state <= PREP;
                  end
               end
            end
            PREP: begin
               r_hi    <= '0;
               r_lo    <= w_a_abs;
               r_mc    <= w_b_abs;
               r_neg   <= w_neg;
               r_cnt   <= r_word ? CW'(31) : CW'(XLEN-1);
               r_state <= CALC;
            end
            CALC: begin
               r_hi <= w_calc_hi;
               r_lo <= w_calc_lo;
               if (r_cnt == '0) begin
                  r_state <= FIX;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            FIX: begin
               r_result    <= w_fix_res;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - table-driven scoreboard bench for muldiv_iter
module tb_muldiv_iter;
   localparam int XLEN = 64;
   localparam int TMO  = 200;

   typedef struct {
      string           name;
      logic [3:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] res;
      int              lat;
   } vec_t;

   typedef struct {
      string           name;
      logic [XLEN-1:0] res;
      int              lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_xfer  = 0;
   vec_t tbl[$];
   exp_t sb_q[$];

   muldiv_iter_if #(.XLEN(XLEN)) bus ();

   muldiv_iter #(.XLEN(XLEN), .W_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.out_valid && bus.out_ready) n_xfer <= n_xfer + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not end, %0d tests so far", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
      end
   endtask

   task automatic add(input string n, input logic [3:0] op, input logic [XLEN-1:0] a, b, r, input int lat);
      vec_t v;
      v.name = n; v.op = op; v.a = a; v.b = b; v.res = r; v.lat = lat;
      tbl.push_back(v);
   endtask

   // Drive one request; returns #1 after the accept edge with the expectation queued.
   task automatic issue(input string name, input logic [3:0] op, input logic [XLEN-1:0] a, b, r, input int lat);
      int   waited;
      exp_t e;
      waited = 0;
      while (!bus.in_ready && waited < TMO) begin
         @(posedge clk); #1;
         waited++;
      end
      check({name, " in_ready"}, XLEN'(bus.in_ready), XLEN'(1));
      bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a  = {$urandom, $urandom};
      bus.b  = {$urandom, $urandom};
      bus.op = 4'($urandom);
      e.name = name; e.res = r; e.lat = lat;
      sb_q.push_back(e);
   endtask

   // Wait for out_valid, counting edges since accept, and compare against the queue head.
   task automatic collect();
      exp_t e;
      int   lat;
      lat = 1;
      while (!bus.out_valid && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
      end
      if (sb_q.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL scoreboard: output with nothing expected");
      end else begin
         e = sb_q.pop_front();
         check({e.name, " result"}, bus.result, e.res);
         check({e.name, " latency"}, XLEN'(lat), XLEN'(e.lat));
      end
   endtask

   initial begin
      logic [XLEN-1:0] prev;
      int              n_ov;
      int              x0;

      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      bus.out_ready = 1'b1;
      reset = 1'b1;

      add("div -7/2",      4'b0100, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 67);
      add("rem -7/2",      4'b0110, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 67);
      add("divu 5/0",      4'b0101, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
      add("remu 5/0",      4'b0111, 64'd5, 64'd0, 64'd5, 1);
      add("div ovf",       4'b0100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
      add("rem ovf",       4'b0110, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1);
      add("mul -1*-1",     4'b0000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd1, 67);
      add("mulh -1*-1",    4'b0001, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 67);
      add("mulhu max",     4'b0011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 67);
      add("mulhsu -1,max", 4'b0010, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 67);
      add("mulw",          4'b1000, 64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 35);
      add("divw ovf",      4'b1100, 64'h80000000, 64'hFFFFFFFF, 64'hFFFFFFFF80000000, 1);
      add("divw -7/2",     4'b1100, 64'h12345678FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 35);
      add("remuw 7%3",     4'b1111, 64'h0000000100000007, 64'd3, 64'd1, 35);
      add("divu 100/7",    4'b0101, 64'd100, 64'd7, 64'd14, 67);
      add("rem 7%-3",      4'b0110, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'd1, 67);
      add("div 7/-3",      4'b0100, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFE, 67);
      add("remw x/0",      4'b1110, 64'h0000000080000005, 64'hABCD000000000000, 64'hFFFFFFFF80000005, 1);
      add("mulh W-form",   4'b1001, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 67);
      add("mul wide",      4'b0000, 64'h123456789, 64'h1000, 64'h123456789000, 67);
      add("mulhu 2^63*4",  4'b0011, 64'h8000000000000000, 64'd4, 64'd2, 67);
      add("remw -7/2",     4'b1110, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 35);
      add("mulw -1*3",     4'b1000, 64'hFFFFFFFF, 64'd3, 64'hFFFFFFFFFFFFFFFD, 35);

      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready",  XLEN'(bus.in_ready),  XLEN'(1));
      check("reset out_valid", XLEN'(bus.out_valid), XLEN'(0));
      check("reset busy",      XLEN'(bus.busy),      XLEN'(0));
      check("reset result",    bus.result,           XLEN'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         issue(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);
         collect();
         @(posedge clk); #1;
      end

      // Flush mid-divide: nothing is ever produced and the unit is free next cycle.
      prev = bus.result;
      issue("flushed div", 4'b0100, 64'd100, 64'd7, 64'd14, 67);
      sb_q.delete();
      repeat (8) @(posedge clk);
      #1;
      check("busy before flush", XLEN'(bus.busy), XLEN'(1));
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("flush in_ready",  XLEN'(bus.in_ready),  XLEN'(1));
      check("flush out_valid", XLEN'(bus.out_valid), XLEN'(0));
      check("flush busy",      XLEN'(bus.busy),      XLEN'(0));
      check("flush result",    bus.result,           prev);
      n_ov = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (bus.out_valid) n_ov++;
      end
      check("flushed op output count", XLEN'(n_ov), XLEN'(0));

      // Flush beats a simultaneous request.
      bus.op = 4'b0101; bus.a = 64'd5; bus.b = 64'd0;
      bus.in_valid = 1'b1; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      check("flush+req busy", XLEN'(bus.busy), XLEN'(0));
      @(posedge clk); #1;
      check("flush+req out_valid", XLEN'(bus.out_valid), XLEN'(0));

      // Backpressure: result held for five cycles, then exactly one transfer.
      bus.out_ready = 1'b0;
      issue("mul 3x4", 4'b0000, 64'd3, 64'd4, 64'd12, 67);
      collect();
      x0 = n_xfer;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("held result", bus.result,           64'd12);
         check("held valid",  XLEN'(bus.out_valid), XLEN'(1));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("post-xfer in_ready",  XLEN'(bus.in_ready),  XLEN'(1));
      check("post-xfer out_valid", XLEN'(bus.out_valid), XLEN'(0));
      check("transfer count",      XLEN'(n_xfer - x0),   XLEN'(1));

      // Flush while a result waits in DONE.
      issue("divu 5/0 held", 4'b0101, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
      collect();
      @(posedge clk); #1;
      check("done held valid", XLEN'(bus.out_valid), XLEN'(1));
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("done flush out_valid", XLEN'(bus.out_valid), XLEN'(0));
      check("done flush in_ready",  XLEN'(bus.in_ready),  XLEN'(1));
      check("done flush result",    bus.result,           64'hFFFFFFFFFFFFFFFF);
      bus.out_ready = 1'b1;

      // Reset mid-op clears the result and frees the unit.
      issue("reset mulhu", 4'b0011, 64'hFFFFFFFFFFFFFFFF, 64'd3, 64'd2, 67);
      sb_q.delete();
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid reset result",    bus.result,           XLEN'(0));
      check("mid reset in_ready",  XLEN'(bus.in_ready),  XLEN'(1));
      check("mid reset busy",      XLEN'(bus.busy),      XLEN'(0));
      check("mid reset out_valid", XLEN'(bus.out_valid), XLEN'(0));

      issue("after reset divu", 4'b0101, 64'd100, 64'd7, 64'd14, 67);
      collect();
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
